byte_unstriping: RTL
====================

# byte_unstriping

- Receive-side counterpart of the two-lane byte striper.
- Merges the two 8-bit lanes (lane 0 carries even bytes, lane 1 carries odd bytes, each held for two clk_2f cycles) back into one 8-bit stream at the clk_2f rate, restoring the original byte order and validity.
- Sits between the lane receivers and the downstream byte consumer, on the same clk_2f domain and reset as the striper.

## Interface

Parameters:
- none; data width fixed at 8 bits.

Ports:
- clk_2f  input  1  double-rate clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk_2f.
- lane_0  input  8  even-order byte; stable across one capture/emit cycle pair.
- lane_1  input  8  odd-order byte; stable across the same pair.
- valid_0  input  1  lane_0 carries a valid byte.
- valid_1  input  1  lane_1 carries a valid byte.
- data_out  output  8  reassembled byte stream.
- valid_out  output  1  data_out is valid this cycle.
- err_out  output  1  sticky lane protocol error. Present only with UNSTRIPE_ERR_EN.

## Operation

Phase state machine (1 bit), two states:
- PH_CAP (0) -> PH_EMIT (1) -> PH_CAP, toggling every clock with reset high.
- Reset forces PH_CAP, so the first active edge after reset release is a capture edge. The striper uses the same reset-release alignment.

PH_CAP edge:
- data_out <= hold1; valid_out <= hold1_v. This emits the lane-1 byte of the previous pair.
- cap0 <= lane_0; cap0_v <= valid_0; hold1 <= lane_1; hold1_v <= valid_1.

PH_EMIT edge:
- data_out <= cap0; valid_out <= cap0_v.
- Lanes are not sampled.

General rules:
- Invalid slots: when valid_out is 0, data_out still carries the stored byte. Only valid_out qualifies it.
- Odd-length burst (valid_0=1, valid_1=0): the lane-0 byte is emitted valid. The following slot has valid_out=0.
- Lane values on PH_EMIT edges are ignored; lane changes mid-pair have no effect.

## Timing

Reset values (reset=0 at a posedge):
- data_out=8'h00, valid_out=0, err_out=0.
- cap0, hold1 = 0; cap0_v, hold1_v = 0; phase=PH_CAP.

Latency, with capture at edge N:
- Lane-0 byte on data_out after edge N+1.
- Lane-1 byte on data_out after edge N+2, which is also the next capture edge.
- Steady state gives back-to-back output with no bubbles.

First output after reset release:
- Edge 0 captures the first pair and outputs the cleared hold (valid_out=0).
- Edge 1 outputs byte 0.

Reset mid-operation:
- Any held bytes are discarded with no output.
- valid_out is 0 on the cycle after the reset edge.
- Phase restarts at PH_CAP on release.

## Configuration

Macro UNSTRIPE_ERR_EN.

Defined:
- Adds the err_out port.
- On a PH_CAP edge with valid_1=1 and valid_0=0 (odd byte without even byte):
  - err_out <= 1, sticky until reset;
  - hold1_v <= 0, so that lane-1 byte is dropped and its slot emits valid_out=0;
  - cap0 handling is unchanged.

Undefined:
- No err_out port and no check.
- The lane-1 byte is emitted with valid_out=1 regardless of valid_0.

## Test plan

- Reset: hold reset=0 for 4 edges with lane_0=8'hA4, valid_0=1 -> data_out=0, valid_out=0 throughout; no capture.
- Continuous burst: pairs FF/EE then DD/CC, valid_0=valid_1=1, starting at the first capture edge -> data_out FF, EE, DD, CC on edges 1-4, valid_out=1 each; then valid_out=0 once the lanes go invalid.
- Odd burst: pair 12/xx with valid_0=1, valid_1=0 -> 12 valid at capture+1; valid_out=0 at capture+2.
- Gap between bursts: 03/04, then one invalid pair, then AA/99 -> stream 03, 04, two invalid slots, AA, 99; order preserved.
- Mid-burst reset: reset=0 one edge after capturing 07/08 -> byte 08 never valid; after release, pair 02/01 yields 02 at edge 1 and 01 at edge 2.
- UNSTRIPE_ERR_EN: capture 55/66 with valid_0=0, valid_1=1 -> err_out=1 from capture+1 until reset; both slots valid_out=0. Without the macro, 66 is emitted valid at capture+2.

Source files
------------

// File: rtl/byte_unstriping.sv
// Two-lane to one-lane byte unstriper (lane 0 = even bytes, lane 1 = odd bytes).
// Latency: lane-0 byte out 1 clk_2f after capture edge, lane-1 byte out 2 after.
// No backpressure: the consumer must accept one byte slot per clk_2f cycle.
//
// Ports:
//   clk_2f            double-rate clock, all state on posedge
//   reset             synchronous active-low reset
//   lane_0 / valid_0  even-order byte and its valid flag
//   lane_1 / valid_1  odd-order byte and its valid flag
//   data_out          reassembled byte stream (qualified by valid_out)
//   valid_out         data_out carries a valid byte this cycle
//   err_out           sticky lane protocol error (only with UNSTRIPE_ERR_EN)
//
// Optional feature macro: UNSTRIPE_ERR_EN enables the odd-without-even check
// and the err_out port.
module byte_unstriping (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic [7:0] lane_0,
    input  logic [7:0] lane_1,
    input  logic       valid_0,
    input  logic       valid_1,
    output logic [7:0] data_out,
    output logic       valid_out
`ifdef UNSTRIPE_ERR_EN
    ,
    output logic       err_out
`endif
);

    typedef enum logic {
        PH_CAP  = 1'b0,
        PH_EMIT = 1'b1
    } phase_t;

    phase_t     phase_q, phase_d;
    logic [7:0] cap0_q, cap0_d;
    logic       cap0_v_q, cap0_v_d;
    logic [7:0] hold1_q, hold1_d;
    logic       hold1_v_q, hold1_v_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
`ifdef UNSTRIPE_ERR_EN
    logic       err_q, err_d;
    logic       odd_err;
`endif

    // Phase register and all datapath state. Reset clears every held byte so
    // nothing captured before a mid-operation reset can ever be emitted.
    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            phase_q   <= PH_CAP;
            cap0_q    <= 8'h00;
            cap0_v_q  <= 1'b0;
            hold1_q   <= 8'h00;
            hold1_v_q <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
`ifdef UNSTRIPE_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            phase_q   <= phase_d;
            cap0_q    <= cap0_d;
            cap0_v_q  <= cap0_v_d;
            hold1_q   <= hold1_d;
            hold1_v_q <= hold1_v_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
`ifdef UNSTRIPE_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

`ifdef UNSTRIPE_ERR_EN
    // An odd byte arriving without its even partner breaks lane alignment.
    assign odd_err = valid_1 & ~valid_0;
`endif

    // Next-state / output logic. Lanes are only sampled on the capture phase;
    // the emit phase replays the stored lane-0 byte.
    always_comb begin
        phase_d   = (phase_q == PH_CAP) ? PH_EMIT : PH_CAP;
        cap0_d    = cap0_q;
        cap0_v_d  = cap0_v_q;
        hold1_d   = hold1_q;
        hold1_v_d = hold1_v_q;
        data_d    = data_q;
        valid_d   = valid_q;
`ifdef UNSTRIPE_ERR_EN
        err_d     = err_q;
`endif
        if (phase_q == PH_CAP) begin
            // Emit the lane-1 byte of the previous pair while capturing
            // the new pair; this is what makes the output bubble-free.
            data_d    = hold1_q;
            valid_d   = hold1_v_q;
            cap0_d    = lane_0;
            cap0_v_d  = valid_0;
            hold1_d   = lane_1;
`ifdef UNSTRIPE_ERR_EN
            hold1_v_d = valid_1 & ~odd_err;
            err_d     = err_q | odd_err;
`else
            hold1_v_d = valid_1;
`endif
        end else begin
            data_d  = cap0_q;
            valid_d = cap0_v_q;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
`ifdef UNSTRIPE_ERR_EN
    assign err_out   = err_q;
`endif

endmodule
